// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - step sequencer driving the voice gate and pitch from a small note table
module note_sequencer #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] loop_last,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_count,
  input  logic [7:0]    wr_gate,
  input  logic [7:0]    wr_len,
  input  logic          wr_rest,
  output logic          trig,
  output logic [31:0]   osc_count,
  output logic [AW-1:0] step,
  output logic          running,
  output logic          step_pulse
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, LOAD, APPLY, PLAY} state_t;

  state_t state, state_nxt;

  logic [31:0] mem_count [DEPTH];
  logic [7:0]  mem_gate  [DEPTH];
  logic [7:0]  mem_len   [DEPTH];
  logic        mem_rest  [DEPTH];

  logic [31:0] rd_count;
  logic [7:0]  rd_gate;
  logic [7:0]  rd_len;
  logic        rd_rest;

  logic [7:0]  gate_cnt;
  logic [7:0]  len_cnt;
  logic        len_done;

  // Read and write share one edge, so a same-address write in LOAD returns the old entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_count[wr_addr] <= wr_count;
      mem_gate[wr_addr]  <= wr_gate;
      mem_len[wr_addr]   <= wr_len;
      mem_rest[wr_addr]  <= wr_rest;
    end
    if (state == LOAD) begin
      rd_count <= mem_count[step];
      rd_gate  <= mem_gate[step];
      rd_len   <= mem_len[step];
      rd_rest  <= mem_rest[step];
    end
  end

  assign len_done   = (state == PLAY) && tick && (len_cnt <= 8'd1);
  assign running    = (state != IDLE);
  assign step_pulse = (state == APPLY);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = APPLY;
      APPLY:   state_nxt = PLAY;
      PLAY:    if (len_done) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    if (stop) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig      <= 1'b0;
      osc_count <= 32'd0;
      step      <= '0;
      gate_cnt  <= 8'd0;
      len_cnt   <= 8'd0;
    end else if (stop) begin
      trig <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) step <= '0;
        APPLY: begin
          if (!rd_rest) osc_count <= rd_count;
          trig     <= !rd_rest && (rd_gate != 8'd0);
          gate_cnt <= rd_gate;
          len_cnt  <= (rd_len == 8'd0) ? 8'd1 : rd_len;
        end
        PLAY: if (tick) begin
          // A gate expiring on the boundary tick leaves trig to the next APPLY (legato tie).
          if (gate_cnt != 8'd0) begin
            gate_cnt <= gate_cnt - 8'd1;
            if (gate_cnt == 8'd1 && !len_done) trig <= 1'b0;
          end
          if (len_cnt != 8'd0) len_cnt <= len_cnt - 8'd1;
          if (len_done) step <= (step >= loop_last) ? '0 : step + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] loop_last = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_count = '0;
  logic [7:0]    wr_gate = '0;
  logic [7:0]    wr_len = '0;
  logic          wr_rest = 1'b0;
  logic          trig;
  logic [31:0]   osc_count;
  logic [AW-1:0] step;
  logic          running;
  logic          step_pulse;

  int checks = 0;
  int errors = 0;

  note_sequencer #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .loop_last(loop_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_count(wr_count), .wr_gate(wr_gate), .wr_len(wr_len), .wr_rest(wr_rest),
    .trig(trig), .osc_count(osc_count), .step(step), .running(running),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input int cnt, input int gate, input int len, input bit rest);
    wr_addr  = AW'(addr);
    wr_count = 32'(cnt);
    wr_gate  = 8'(gate);
    wr_len   = 8'(len);
    wr_rest  = rest;
    wr_en    = 1'b1;
    step_clk();
    wr_en    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step_clk();
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
    check("rst_trig", trig, 0);
    check("rst_osc", osc_count, 0);
    check("rst_step", step, 0);
    check("rst_running", running, 0);
    check("rst_pulse", step_pulse, 0);

    // basic step
    write_entry(0, 1000, 2, 4, 0);
    loop_last = 4'd0;
    do_start();
    check("t1_load_running", running, 1);
    check("t1_load_trig", trig, 0);
    step_clk();
    check("t1_apply_pulse", step_pulse, 1);
    step_clk();
    check("t1_trig_on", trig, 1);
    check("t1_osc", osc_count, 1000);
    check("t1_pulse_off", step_pulse, 0);
    do_tick();
    check("t1_trig_tick1", trig, 1);
    do_tick();
    check("t1_trig_tick2", trig, 0);
    do_tick();
    check("t1_running_tick3", running, 1);
    do_tick();
    check("t1_pulse_early", step_pulse, 0);
    step_clk();
    check("t1_pulse_repeat", step_pulse, 1);
    step_clk();
    check("t1_retrig", trig, 1);
    do_stop();

    // loop and wrap
    write_entry(0, 100, 1, 1, 0);
    write_entry(1, 200, 1, 1, 0);
    write_entry(2, 300, 1, 1, 0);
    loop_last = 4'd2;
    do_start();
    step_clk();
    step_clk();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t2_osc%0d", i), osc_count, 32'((i % 3 + 1) * 100));
      check($sformatf("t2_step%0d", i), step, 32'(i % 3));
      do_tick();
      step_clk();
      step_clk();
    end
    do_stop();

    // rest and tie
    write_entry(0, 500, 5, 3, 0);
    write_entry(1, 999, 4, 2, 1);
    write_entry(2, 700, 9, 2, 0);
    write_entry(3, 800, 1, 1, 0);
    loop_last = 4'd3;
    do_start();
    step_clk();
    step_clk();
    check("t3_s0_osc", osc_count, 500);
    check("t3_s0_trig", trig, 1);
    do_tick();
    do_tick();
    do_tick();
    check("t3_load1_trig", trig, 1);
    step_clk();
    step_clk();
    check("t3_rest_trig", trig, 0);
    check("t3_rest_osc", osc_count, 500);
    check("t3_rest_step", step, 1);
    do_tick();
    do_tick();
    step_clk();
    step_clk();
    check("t3_s2_osc", osc_count, 700);
    check("t3_s2_trig", trig, 1);
    do_tick();
    do_tick();
    check("t3_tie_load", trig, 1);
    step_clk();
    check("t3_tie_apply", trig, 1);
    step_clk();
    check("t3_tie_play", trig, 1);
    check("t3_s3_osc", osc_count, 800);
    do_stop();

    // strobe priority
    start = 1'b1;
    stop  = 1'b1;
    step_clk();
    start = 1'b0;
    stop  = 1'b0;
    check("t4_both_running", running, 0);
    step_clk();
    check("t4_both_pulse", step_pulse, 0);
    do_start();
    step_clk();
    step_clk();
    check("t4_play_trig", trig, 1);
    do_stop();
    check("t4_stop_trig", trig, 0);
    check("t4_stop_running", running, 0);
    check("t4_stop_osc", osc_count, 500);
    check("t4_stop_step", step, 0);

    // edge values: len=0, gate=0, ticks in LOAD/APPLY, write during LOAD
    write_entry(0, 111, 0, 0, 0);
    write_entry(1, 222, 3, 5, 0);
    loop_last = 4'd1;
    do_start();
    step_clk();
    step_clk();
    check("t5_gate0_osc", osc_count, 111);
    check("t5_gate0_trig", trig, 0);
    do_tick();
    check("t5_len0_step", step, 1);
    check("t5_len0_trig", trig, 0);
    do_tick();
    check("t5_apply_pulse", step_pulse, 1);
    do_tick();
    check("t5_s1_osc", osc_count, 222);
    check("t5_s1_trig", trig, 1);
    for (int i = 0; i < 4; i++) do_tick();
    check("t5_notick_step", step, 1);
    check("t5_gate_expired", trig, 0);
    do_tick();
    check("t5_wrap_step", step, 0);
    write_entry(0, 333, 2, 1, 0);
    step_clk();
    check("t5_old_osc", osc_count, 111);
    check("t5_old_trig", trig, 0);
    do_tick();
    step_clk();
    step_clk();
    for (int i = 0; i < 5; i++) do_tick();
    step_clk();
    step_clk();
    check("t5_new_osc", osc_count, 333);
    check("t5_new_trig", trig, 1);

    // reset mid-play
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    check("t6_trig", trig, 0);
    check("t6_osc", osc_count, 0);
    check("t6_step", step, 0);
    check("t6_running", running, 0);
    check("t6_pulse", step_pulse, 0);
    do_start();
    step_clk();
    step_clk();
    check("t6_replay_osc", osc_count, 333);
    check("t6_replay_trig", trig, 1);
    check("t6_replay_step", step, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
